// File: rtl/mac_seq_ctrl.sv
`timescale 1ns/1ps
// mac_seq_ctrl: walks one dot-product command through an external MAC, keeping a
// single operand pair in flight, with a per-beat completion timeout and abort.
module mac_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic                    abort,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [7:0]       in_a,
  input  logic signed [7:0]       in_b,
  output logic                    mac_clear,
  output logic                    mac_valid,
  output logic signed [7:0]       mac_a,
  output logic signed [7:0]       mac_b,
  input  logic signed [31:0]      mac_y,
  input  logic                    mac_overflow,
  input  logic                    mac_done,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [31:0]      res_y,
  output logic                    res_ovf,
  output logic                    res_err
);
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int CNT_W  = $clog2(TIMEOUT + 2);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_WAIT, S_RESULT} state_t;

  state_t                    state, state_nxt;
  logic [LEN_W-1:0]          remaining, remaining_nxt;
  logic [CNT_W-1:0]          cnt, cnt_nxt;
  logic                      mac_clear_nxt, mac_valid_nxt;
  logic signed [DATA_W-1:0]  mac_a_nxt, mac_b_nxt;
  logic                      res_valid_nxt, res_ovf_nxt, res_err_nxt;
  logic signed [ACC_W-1:0]   res_y_nxt;

  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_FEED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      cnt       <= '0;
      mac_clear <= 1'b1;
      mac_valid <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_y     <= '0;
      res_ovf   <= 1'b0;
      res_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      cnt       <= cnt_nxt;
      mac_clear <= mac_clear_nxt;
      mac_valid <= mac_valid_nxt;
      mac_a     <= mac_a_nxt;
      mac_b     <= mac_b_nxt;
      res_valid <= res_valid_nxt;
      res_y     <= res_y_nxt;
      res_ovf   <= res_ovf_nxt;
      res_err   <= res_err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    cnt_nxt       = cnt;
    mac_clear_nxt = 1'b0;
    mac_valid_nxt = 1'b0;
    mac_a_nxt     = mac_a;
    mac_b_nxt     = mac_b;
    res_valid_nxt = res_valid;
    res_y_nxt     = res_y;
    res_ovf_nxt   = res_ovf;
    res_err_nxt   = res_err;
    // Abort beats every other event, including a same-cycle operand handshake.
    if (abort && (state != S_IDLE)) begin
      state_nxt     = S_IDLE;
      mac_clear_nxt = 1'b1;
      res_valid_nxt = 1'b0;
      cnt_nxt       = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            remaining_nxt = cmd_len;
            res_ovf_nxt   = 1'b0;
            res_err_nxt   = 1'b0;
            mac_clear_nxt = 1'b1;
            state_nxt     = S_CLEAR;
          end
        end
        S_CLEAR: begin
          if (remaining != '0) begin
            state_nxt = S_FEED;
          end else begin
            res_y_nxt     = '0;
            res_valid_nxt = 1'b1;
            state_nxt     = S_RESULT;
          end
        end
        S_FEED: begin
          if (in_valid) begin
            mac_a_nxt     = in_a;
            mac_b_nxt     = in_b;
            mac_valid_nxt = 1'b1;
            remaining_nxt = remaining - LEN_W'(1);
            cnt_nxt       = '0;
            state_nxt     = S_WAIT;
          end
        end
        S_WAIT: begin
          // The strobe cycle itself cannot carry a completion for this beat.
          if (mac_valid) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (mac_done) begin
            res_ovf_nxt = res_ovf | mac_overflow;
            res_y_nxt   = mac_y;
            if (remaining != '0) begin
              state_nxt = S_FEED;
            end else begin
              res_valid_nxt = 1'b1;
              state_nxt     = S_RESULT;
            end
          end else if (cnt == CNT_LIMIT) begin
            res_err_nxt   = 1'b1;
            res_y_nxt     = '0;
            res_valid_nxt = 1'b1;
            state_nxt     = S_RESULT;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_nxt = 1'b0;
            state_nxt     = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, width of the dot-product length field.
REQ-002 Parameter TIMEOUT, default 16, max cycles to wait for mac_done per beat.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 cmd_len  input  LEN_W  number of operand pairs to accumulate (unsigned).
REQ-007 abort  input  1  synchronous abort of the current command.
REQ-008 in_valid / in_ready  input / output  1 / 1  operand stream handshake.
REQ-009 in_a, in_b  input  8 each  signed operands.
REQ-010 mac_clear  output  1  drives the MAC accumulator reset.
REQ-011 mac_valid  output  1  one-cycle operation strobe to the MAC.
REQ-012 mac_a, mac_b  output  8 each  signed operands to the MAC.
REQ-013 mac_y  input  32  signed MAC accumulator value.
REQ-014 mac_overflow, mac_done  input  1 each  MAC status; mac_done pulses when mac_y includes the last beat.
REQ-015 res_valid / res_ready  output / input  1 / 1  result handshake.
REQ-016 res_y  output  32  signed dot-product result.
REQ-017 res_ovf, res_err  output  1 each  sticky overflow flag; timeout flag.

Function
REQ-018 FSM states IDLE, CLEAR, FEED, WAIT, RESULT; all outputs registered except cmd_ready and in_ready, which decode directly from state.
REQ-019 IDLE: cmd_ready=1; on cmd_valid, latch cmd_len into remaining, clear res_ovf/res_err, go CLEAR.
REQ-020 CLEAR: mac_clear=1 for exactly one cycle; next state FEED if remaining!=0, else RESULT with res_y=0.
REQ-021 FEED: in_ready=1; on in_valid&&in_ready, register in_a/in_b to mac_a/mac_b, pulse mac_valid next cycle, decrement remaining, go WAIT.
REQ-022 At most one MAC operation outstanding; in_ready=0 in every state except FEED.
REQ-023 WAIT: counter starts at 0 in the cycle mac_valid is high; mac_done in that same cycle is ignored.
REQ-024 WAIT on mac_done: res_ovf |= mac_overflow; capture mac_y into res_y; go FEED if remaining!=0, else RESULT.
REQ-025 WAIT timeout: counter reaching TIMEOUT without mac_done sets res_err=1, res_y=0, goes RESULT; unconsumed operands stay unconsumed.
REQ-026 Overflow does not stop the command; all cmd_len pairs are still consumed.
REQ-027 RESULT: res_valid=1; res_y/res_ovf/res_err held stable until res_ready; on res_valid&&res_ready go IDLE.
REQ-028 abort in CLEAR/FEED/WAIT/RESULT: next cycle mac_clear=1 for one cycle, res_valid=0, state IDLE; no result delivered; abort in IDLE has no effect.
REQ-029 abort and in_valid in the same FEED cycle: abort wins, the operand is not consumed.
REQ-030 mac_done or mac_overflow outside WAIT is ignored.
REQ-031 Latency per beat: handshake at edge k -> mac_valid high in cycle k+1; the next in_ready comes in the cycle after mac_done is sampled.

Reset
REQ-032 reset asserted: state IDLE, remaining=0, mac_valid=0, mac_clear=1, mac_a=mac_b=0, res_valid=0, res_y=0, res_ovf=0, res_err=0, timeout counter 0.
REQ-033 First cycle after reset release: mac_clear=0; reset mid-command discards the command with no result.

Verification
REQ-034 cmd_len=3, pairs (2,3),(-4,5),(7,-1), MAC model done 1 cycle after valid -> one mac_clear pulse, 3 mac_valid pulses, res_y=-21, res_ovf=0.
REQ-035 cmd_len=0 -> mac_clear pulse, res_valid with res_y=0, in_ready never asserted.
REQ-036 Model forces mac_overflow=1 on beat 2 of 4 -> all 4 pairs consumed, res_ovf=1, res_err=0.
REQ-037 Model never asserts mac_done -> res_valid TIMEOUT+1 cycles after mac_valid, res_err=1, res_y=0.
REQ-038 abort asserted in WAIT of beat 2, same cycle as in_valid -> mac_clear pulse, IDLE, no res_valid; next command (len=1, 127*127) -> res_y=16129.
REQ-039 res_ready held low 10 cycles -> res_valid/res_y stable throughout, cmd_ready=0 until the handshake.
